// File: rtl/linreg_seq_ctrl_pkg.sv
// Shared types and default sizing for the linear-regression sequencing controller.
// The state encodings are fixed because they are exported on the debug port.
package linreg_pkg;

  localparam int DEFAULT_DEPTH   = 150;
  localparam int DEFAULT_ADDR_W  = $clog2(DEFAULT_DEPTH);
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT    = 4'd1,
    LOAD    = 4'd2,
    C_START = 4'd3,
    C_READ  = 4'd4,
    C_WAIT  = 4'd5,
    C_FIN   = 4'd6,
    E_START = 4'd7,
    E_READ  = 4'd8,
    E_WAIT  = 4'd9,
    DONE    = 4'd10,
    FAULT   = 4'd11
  } ctrl_state_t;

  // The wait counter only has to hold values up to TIMEOUT-1.
  function automatic int timer_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/linreg_seq_ctrl_if.sv
// Host/memory/datapath handshake bundle for linreg_seq_ctrl.
// master = host/testbench side, slave = the controller.
interface linreg_seq_ctrl_if
  import linreg_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int CNT_W  = ADDR_W + 1
);

  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  n_samples;
  logic              in_valid;
  logic              in_ready;
  logic              coef_done;
  logic              coef_finish;
  logic              err_done;
  logic              dp_clr;
  logic              w_en;
  logic              r_en;
  logic [ADDR_W-1:0] addr;
  logic              en_coef;
  logic              en_err;
  logic              busy;
  logic              done;
  logic              fault;
  logic [3:0]        state;

  modport master (
    output start, abort, n_samples, in_valid, coef_done, coef_finish, err_done,
    input  in_ready, dp_clr, w_en, r_en, addr, en_coef, en_err, busy, done, fault, state
  );

  modport slave (
    input  start, abort, n_samples, in_valid, coef_done, coef_finish, err_done,
    output in_ready, dp_clr, w_en, r_en, addr, en_coef, en_err, busy, done, fault, state
  );

endinterface

// File: rtl/linreg_seq_ctrl_wait_timer.sv
// Wait-state watchdog: counts cycles while en is high, clr restarts it.
// expired is high in the TIMEOUT-th counted cycle; TIMEOUT = 0 disables it.
module wait_timer
  import linreg_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT     = timer_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clr, en};
      assign expired       = 1'b0;
    end else begin : g_on
      logic [CNT-1:0] cnt_q;
      logic [CNT-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Independent of clr so the FSM can use it without a combinational loop.
      assign expired = en && (cnt_q == CNT'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/linreg_seq_ctrl.sv
// Sequencing controller: loads N samples, then runs a coefficient pass and an
// error pass over them, each point gated by a datapath done strobe with timeout.
module linreg_seq_ctrl
  import linreg_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int CNT_W   = ADDR_W + 1,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  linreg_seq_ctrl_if.slave bus
);

  ctrl_state_t       state_q;
  ctrl_state_t       state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  n_d;
  logic              fault_q;
  logic              fault_d;

  logic [CNT_W-1:0]  n_clamped;
  logic [CNT_W-1:0]  last_idx;
  logic [ADDR_W-1:0] addr_inc;
  logic              at_last;
  logic              timer_clr;
  logic              timer_en;
  logic              timer_expired;

  assign n_clamped = (bus.n_samples > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.n_samples;
  assign last_idx  = n_q - 1'b1;
  assign at_last   = (CNT_W'(addr_q) == last_idx);
  assign addr_inc  = addr_q + 1'b1;

  // Any state change restarts the count, so each wait state starts from zero.
  assign timer_en  = (state_q == C_WAIT) || (state_q == C_FIN) || (state_q == E_WAIT);
  assign timer_clr = (state_d != state_q);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    n_d     = n_q;
    fault_d = fault_q;

    case (state_q)
      IDLE, FAULT: begin
        if (bus.start) begin
          n_d     = n_clamped;
          addr_d  = '0;
          fault_d = 1'b0;
          state_d = INIT;
        end
      end
      INIT: begin
        addr_d  = '0;
        state_d = (n_q == '0) ? DONE : LOAD;
      end
      LOAD: begin
        if (bus.in_valid) begin
          if (at_last) begin
            addr_d  = '0;
            state_d = C_START;
          end else begin
            addr_d = addr_inc;
          end
        end
      end
      C_START: state_d = C_READ;
      C_READ:  state_d = C_WAIT;
      C_WAIT: begin
        if (bus.coef_done) begin
          if (at_last) begin
            state_d = C_FIN;
          end else begin
            addr_d  = addr_inc;
            state_d = C_READ;
          end
        end else if (timer_expired) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end
      C_FIN: begin
        if (bus.coef_finish) begin
          addr_d  = '0;
          state_d = E_START;
        end else if (timer_expired) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end
      E_START: state_d = E_READ;
      E_READ:  state_d = E_WAIT;
      E_WAIT: begin
        if (bus.err_done) begin
          if (at_last) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_inc;
            state_d = E_READ;
          end
        end else if (timer_expired) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything but keeps the sticky fault and latched count.
    if (bus.abort) begin
      state_d = IDLE;
      addr_d  = '0;
      n_d     = n_q;
      fault_d = fault_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      n_q     <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      fault_q <= fault_d;
    end
  end

  assign bus.in_ready = (state_q == LOAD);
  assign bus.w_en     = (state_q == LOAD) && bus.in_valid;
  assign bus.dp_clr   = (state_q == INIT);
  assign bus.r_en     = (state_q == C_READ) || (state_q == C_WAIT) ||
                        (state_q == E_READ) || (state_q == E_WAIT);
  assign bus.addr     = addr_q;
  assign bus.en_coef  = (state_q == C_START);
  assign bus.en_err   = (state_q == E_START);
  assign bus.busy     = (state_q != IDLE) && (state_q != FAULT);
  assign bus.done     = (state_q == DONE);
  assign bus.fault    = fault_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_linreg_seq_ctrl.sv
// Directed and randomized bench for linreg_seq_ctrl: expectations come from
// the run-level rules (N clamp, per-phase cycle sums, addresses 0..N-1).
module tb_linreg_seq_ctrl;
  import linreg_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int TO    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int mon_wr = 0, mon_rd = 0, mon_clr = 0, mon_coef = 0, mon_err = 0, mon_done = 0;

  linreg_seq_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  linreg_seq_ctrl #(
    .DEPTH   (DEPTH),
    .ADDR_W  (AW),
    .CNT_W   (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters, sampled mid-low-phase after inputs have settled.
  always begin
    @(negedge clk);
    #2;
    if (bus.w_en)    mon_wr++;
    if (bus.r_en)    mon_rd++;
    if (bus.dp_clr)  mon_clr++;
    if (bus.en_coef) mon_coef++;
    if (bus.en_err)  mon_err++;
    if (bus.done)    mon_done++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chkn(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int pick_delay(input int dmode);
    if (dmode == 0) return 1;
    if (dmode == 2) return TO;
    return int'($urandom_range(1, TO));
  endfunction

  // special: 0 normal, 1 abort in error pass at point spt, 2 reset after spt
  // accepted samples, 3 coefficient strobe never returned.
  task automatic do_run(input int n_req, input int vmode, input int dmode,
                        input int special, input int spt);
    int   n, len, acc, dly, fin, exp_cyc, rd_cycles, t0;
    int   s_wr, s_rd, s_clr, s_coef, s_err, s_done;
    logic v;
    n = (n_req > DEPTH) ? DEPTH : n_req;

    @(negedge clk);
    s_wr = mon_wr; s_rd = mon_rd; s_clr = mon_clr;
    s_coef = mon_coef; s_err = mon_err; s_done = mon_done;
    t0 = cyc;
    bus.n_samples = CW'(n_req);
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    chk1("init_dp_clr", bus.dp_clr, 1'b1);
    chk1("init_fault_clear", bus.fault, 1'b0);
    chk1("init_busy", bus.busy, 1'b1);

    if (n == 0) begin
      step();
      chk1("zero_done", bus.done, 1'b1);
      chkn("zero_latency", cyc - t0, 2);
      step();
      chk1("zero_idle", bus.busy, 1'b0);
      chkn("zero_writes", mon_wr - s_wr, 0);
      chkn("zero_reads", mon_rd - s_rd, 0);
      $display("run n_req=%0d n=0 done_after=2", n_req);
      return;
    end

    exp_cyc = 2; acc = 0; len = 0; rd_cycles = 0;
    while (acc < n) begin
      @(negedge clk);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (len % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1) || (len >= 3 * n + 4);
      endcase
      bus.in_valid = v;
      #1;
      chk1("load_in_ready", bus.in_ready, 1'b1);
      chk1("load_w_en", bus.w_en, v);
      if (v) chkn("load_addr", int'(bus.addr), acc);
      len++;
      if (v) acc++;
      if (special == 2 && acc == spt) begin
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        step();
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_w_en", bus.w_en, 1'b0);
        chk1("rst_r_en", bus.r_en, 1'b0);
        chk1("rst_dp_clr", bus.dp_clr, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk1("rst_fault", bus.fault, 1'b0);
        chkn("rst_addr", int'(bus.addr), 0);
        chkn("rst_state", int'(bus.state), int'(IDLE));
        rst = 1'b0;
        bus.in_valid = 1'b0;
        $display("run n_req=%0d reset after %0d samples", n_req, spt);
        return;
      end
    end
    exp_cyc += len;

    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk1("c_start_en_coef", bus.en_coef, 1'b1);
    chk1("c_start_in_ready", bus.in_ready, 1'b0);
    chkn("c_start_addr", int'(bus.addr), 0);
    if (vmode == 1) chkn("toggle_load_len", len, 2 * n - 1);
    exp_cyc += 1;

    step();
    for (int i = 0; i < n; i++) begin
      chk1("c_read_r_en", bus.r_en, 1'b1);
      chkn("c_read_addr", int'(bus.addr), i);
      if (special == 3) begin
        for (int k = 1; k <= TO; k++) begin
          step();
          chk1("hang_r_en", bus.r_en, 1'b1);
          chk1("hang_fault", bus.fault, 1'b0);
          chkn("hang_addr", int'(bus.addr), 0);
        end
        step();
        chk1("timeout_fault", bus.fault, 1'b1);
        chk1("timeout_busy", bus.busy, 1'b0);
        chk1("timeout_r_en", bus.r_en, 1'b0);
        step();
        chk1("fault_sticky", bus.fault, 1'b1);
        $display("run n_req=%0d timed out in coefficient wait", n_req);
        return;
      end
      dly = pick_delay(dmode);
      for (int k = 1; k <= dly; k++) begin
        step();
        chk1("c_wait_r_en", bus.r_en, 1'b1);
        chkn("c_wait_addr", int'(bus.addr), i);
        if (k == dly) bus.coef_done = 1'b1;
      end
      step();
      bus.coef_done = 1'b0;
      exp_cyc   += 1 + dly;
      rd_cycles += 1 + dly;
    end

    chk1("c_fin_r_en", bus.r_en, 1'b0);
    chk1("c_fin_busy", bus.busy, 1'b1);
    fin = pick_delay(dmode);
    for (int k = 1; k <= fin; k++) begin
      if (k == fin) bus.coef_finish = 1'b1;
      step();
    end
    bus.coef_finish = 1'b0;
    exp_cyc += fin + 1;
    chk1("e_start_en_err", bus.en_err, 1'b1);
    chkn("e_start_addr", int'(bus.addr), 0);

    step();
    for (int i = 0; i < n; i++) begin
      chk1("e_read_r_en", bus.r_en, 1'b1);
      chkn("e_read_addr", int'(bus.addr), i);
      if (special == 1 && i == spt) begin
        step();
        chk1("abort_wait_r_en", bus.r_en, 1'b1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk1("abort_busy", bus.busy, 1'b0);
        chk1("abort_r_en", bus.r_en, 1'b0);
        chk1("abort_done", bus.done, 1'b0);
        repeat (3) step();
        chkn("abort_no_done", mon_done - s_done, 0);
        $display("run n_req=%0d aborted at error point %0d", n_req, spt);
        return;
      end
      dly = pick_delay(dmode);
      for (int k = 1; k <= dly; k++) begin
        step();
        chk1("e_wait_r_en", bus.r_en, 1'b1);
        chkn("e_wait_addr", int'(bus.addr), i);
        if (k == dly) bus.err_done = 1'b1;
      end
      step();
      bus.err_done = 1'b0;
      exp_cyc   += 1 + dly;
      rd_cycles += 1 + dly;
    end

    chk1("done_pulse", bus.done, 1'b1);
    chk1("done_busy", bus.busy, 1'b1);
    chkn("done_latency", cyc - t0, exp_cyc);
    step();
    chk1("after_done", bus.done, 1'b0);
    chk1("after_busy", bus.busy, 1'b0);
    chkn("after_state", int'(bus.state), int'(IDLE));
    chkn("run_writes", mon_wr - s_wr, n);
    chkn("run_read_cycles", mon_rd - s_rd, rd_cycles);
    chkn("run_dp_clr", mon_clr - s_clr, 1);
    chkn("run_en_coef", mon_coef - s_coef, 1);
    chkn("run_en_err", mon_err - s_err, 1);
    chkn("run_done", mon_done - s_done, 1);
    $display("run n_req=%0d n=%0d load_cycles=%0d done_after=%0d", n_req, n, len, exp_cyc);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.n_samples   = '0;
    bus.in_valid    = 1'b0;
    bus.coef_done   = 1'b0;
    bus.coef_finish = 1'b0;
    bus.err_done    = 1'b0;
    rst             = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk1("reset_busy", bus.busy, 1'b0);
    chk1("reset_in_ready", bus.in_ready, 1'b0);
    chk1("reset_r_en", bus.r_en, 1'b0);
    chk1("reset_done", bus.done, 1'b0);
    chk1("reset_fault", bus.fault, 1'b0);
    chkn("reset_addr", int'(bus.addr), 0);
    chkn("reset_state", int'(bus.state), int'(IDLE));
    rst = 1'b0;

    // N=4, immediate strobes: 5N+6 cycles inclusive of start and DONE.
    do_run(4, 0, 0, 0, 0);
    do_run(3, 1, 0, 0, 0);
    do_run(0, 0, 0, 0, 0);
    do_run(DEPTH + 5, 0, 0, 0, 0);
    do_run(2, 0, 2, 0, 0);
    do_run(2, 0, 0, 3, 0);
    do_run(3, 2, 1, 0, 0);
    do_run(4, 0, 1, 1, 2);
    do_run(5, 0, 0, 2, 2);
    for (int r = 0; r < 8; r++) begin
      do_run(int'($urandom_range(1, DEPTH + 3)), 2, 1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
